// File: rtl/spongent_pkg.sv
// Shared Spongent round-constant definitions: per-variant LFSR constants, controller state
// type and the bit-reversal helper used to align the reversed constant.
package spongent_pkg;

    // Spongent-88
    localparam int unsigned SPONGENT88_LFSR_W  = 6;
    localparam logic [5:0]  SPONGENT88_TAPS    = 6'b110000;
    localparam logic [5:0]  SPONGENT88_INIT    = 6'h05;
    localparam int unsigned SPONGENT88_ROUNDS  = 45;

    // Spongent-128
    localparam int unsigned SPONGENT128_LFSR_W = 7;
    localparam logic [6:0]  SPONGENT128_TAPS   = 7'b1100000;
    localparam logic [6:0]  SPONGENT128_INIT   = 7'h7A;
    localparam int unsigned SPONGENT128_ROUNDS = 70;

    // Spongent-160
    localparam int unsigned SPONGENT160_LFSR_W = 7;
    localparam logic [6:0]  SPONGENT160_TAPS   = 7'b1100000;
    localparam logic [6:0]  SPONGENT160_INIT   = 7'h45;
    localparam int unsigned SPONGENT160_ROUNDS = 90;

    // Spongent-224
    localparam int unsigned SPONGENT224_LFSR_W = 8;
    localparam logic [7:0]  SPONGENT224_TAPS   = 8'b10001110;
    localparam logic [7:0]  SPONGENT224_INIT   = 8'h01;
    localparam int unsigned SPONGENT224_ROUNDS = 120;

    // Spongent-256
    localparam int unsigned SPONGENT256_LFSR_W = 9;
    localparam logic [8:0]  SPONGENT256_TAPS   = 9'b100010000;
    localparam logic [8:0]  SPONGENT256_INIT   = 9'h9E;
    localparam int unsigned SPONGENT256_ROUNDS = 140;

    // Widest value bit_reverse can handle.
    localparam int unsigned MaxRevW    = 32;
    localparam int unsigned MaxRevIdxW = $clog2(MaxRevW);

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } rc_state_e;

    // Reverses the low w bits of v into the low w bits of the result; upper bits are zero.
    function automatic logic [MaxRevW-1:0] bit_reverse(input logic [MaxRevW-1:0] v,
                                                       input int unsigned       w);
        logic [MaxRevW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MaxRevW; i++) begin
            if (i < w) begin
                r[MaxRevIdxW'(w - 1 - i)] = v[MaxRevIdxW'(i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/spongent_lfsr_core.sv
// Round-counter LFSR: left-shifting Fibonacci register with a tap mask, reloadable to INIT.
module spongent_lfsr_core #(
    parameter int unsigned       LFSR_W = 6,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(6'b110000),
    parameter logic [LFSR_W-1:0] INIT   = LFSR_W'(6'h05)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    output logic [LFSR_W-1:0] state
);

    logic fb;

    assign fb = ^(state & TAPS);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            state <= INIT;
        end else if (en) begin
            state <= {state[LFSR_W-2:0], fb};
        end
    end

endmodule

// File: rtl/spongent_round_counter.sv
// Spongent round-constant generator: start/step controlled LFSR with round index, aligned
// forward/reversed constants, last-round, done and lock-up flags.
module spongent_round_counter
    import spongent_pkg::*;
#(
    parameter int unsigned       LFSR_W = SPONGENT88_LFSR_W,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(SPONGENT88_TAPS),
    parameter logic [LFSR_W-1:0] INIT   = LFSR_W'(SPONGENT88_INIT),
    parameter int unsigned       ROUNDS = SPONGENT88_ROUNDS,
    parameter int unsigned       OUT_W  = 16,
    parameter int unsigned       IDX_W  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    output logic             busy,
    output logic [IDX_W-1:0] round_idx,
    output logic [OUT_W-1:0] lc,
    output logic [OUT_W-1:0] lc_rev,
    output logic             last,
    output logic             done,
    output logic             err
);

    if (OUT_W < LFSR_W) begin : g_chk_out_w
        $error("OUT_W must be >= LFSR_W");
    end
    if (OUT_W > MaxRevW || LFSR_W < 2) begin : g_chk_range
        $error("LFSR_W must be >= 2 and OUT_W must not exceed MaxRevW");
    end
    if (TAPS[LFSR_W-1] != 1'b1) begin : g_chk_taps
        $error("TAPS must include the MSB of the LFSR");
    end
    if (INIT == '0) begin : g_chk_init
        $error("INIT must be non-zero");
    end
    if (ROUNDS < 1) begin : g_chk_rounds
        $error("ROUNDS must be >= 1");
    end

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(ROUNDS - 1);

    rc_state_e          fsm;
    logic [IDX_W-1:0]   idx_q;
    logic               done_q;
    logic               err_q;
    logic [LFSR_W-1:0]  state;
    logic               busy_w;
    logic               at_last;
    logic               fire;
    logic               lfsr_load;
    logic               lfsr_en;
    logic [MaxRevW-1:0] rev_full;

    assign busy_w  = (fsm == StRun);
    assign at_last = (idx_q == LastIdx);
    // start beats step, so a step in the same cycle as start never advances anything.
    assign fire    = busy_w && step && !start;

    // The final step reloads INIT so the next call begins from a known state.
    assign lfsr_load = start || (fire && at_last);
    assign lfsr_en   = fire && !at_last;

    spongent_lfsr_core #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .INIT   (INIT)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .en    (lfsr_en),
        .state (state)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm    <= StIdle;
            idx_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (busy_w && (state == '0)) begin
                err_q <= 1'b1;
            end
            case (fsm)
                StIdle: begin
                    if (start) begin
                        fsm   <= StRun;
                        idx_q <= '0;
                    end
                end
                StRun: begin
                    if (start) begin
                        idx_q <= '0;
                    end else if (step) begin
                        if (at_last) begin
                            fsm    <= StIdle;
                            idx_q  <= '0;
                            done_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    fsm   <= StIdle;
                    idx_q <= '0;
                end
            endcase
        end
    end

    always_comb begin
        rev_full = bit_reverse(MaxRevW'(state), LFSR_W);
        lc       = OUT_W'(state);
        lc_rev   = OUT_W'(rev_full << (OUT_W - LFSR_W));
    end

    assign busy      = busy_w;
    assign round_idx = idx_q;
    assign last      = busy_w && at_last;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_spongent_round_counter.sv
// Bench for spongent_round_counter: three variants (88/128/256) checked cycle by cycle
// against an arithmetic reference model plus directed sequence and priority checks.
module tb_spongent_round_counter;
    import spongent_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start  [3];
    logic        step   [3];
    logic        busy   [3];
    logic        last   [3];
    logic        done   [3];
    logic        err    [3];
    logic [15:0] lc     [3];
    logic [15:0] lc_rev [3];
    logic [5:0]  idx0;
    logic [6:0]  idx1;
    logic [7:0]  idx2;

    spongent_round_counter u88 (
        .clk(clk), .rst(rst), .start(start[0]), .step(step[0]), .busy(busy[0]),
        .round_idx(idx0), .lc(lc[0]), .lc_rev(lc_rev[0]), .last(last[0]), .done(done[0]),
        .err(err[0])
    );

    spongent_round_counter #(
        .LFSR_W(SPONGENT128_LFSR_W), .TAPS(SPONGENT128_TAPS), .INIT(SPONGENT128_INIT),
        .ROUNDS(SPONGENT128_ROUNDS)
    ) u128 (
        .clk(clk), .rst(rst), .start(start[1]), .step(step[1]), .busy(busy[1]),
        .round_idx(idx1), .lc(lc[1]), .lc_rev(lc_rev[1]), .last(last[1]), .done(done[1]),
        .err(err[1])
    );

    spongent_round_counter #(
        .LFSR_W(SPONGENT256_LFSR_W), .TAPS(SPONGENT256_TAPS), .INIT(SPONGENT256_INIT),
        .ROUNDS(SPONGENT256_ROUNDS)
    ) u256 (
        .clk(clk), .rst(rst), .start(start[2]), .step(step[2]), .busy(busy[2]),
        .round_idx(idx2), .lc(lc[2]), .lc_rev(lc_rev[2]), .last(last[2]), .done(done[2]),
        .err(err[2])
    );

    // Reference model parameters, written out independently of the package.
    int unsigned mw    [3] = '{6, 7, 9};
    int unsigned mtaps [3] = '{'h30, 'h60, 'h110};
    int unsigned minit [3] = '{'h05, 'h7A, 'h9E};
    int unsigned mr    [3] = '{45, 70, 140};

    bit          m_busy [3];
    int unsigned m_idx  [3];
    int unsigned m_s    [3];
    bit          m_done [3];
    bit          m_err  [3];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int done_seen [3];
    int seen1 [int];
    int seen2 [int];

    function automatic int unsigned model_next(int unsigned s, int unsigned taps, int unsigned w);
        int unsigned fb;
        fb = $countones(s & taps) % 2;
        return ((s * 2) + fb) % (1 << w);
    endfunction

    function automatic int unsigned model_rev(int unsigned s, int unsigned w);
        int unsigned r;
        r = 0;
        for (int i = 0; i < int'(w); i++) begin
            if (((s >> i) & 1) != 0) r = r | (1 << (15 - i));
        end
        return r;
    endfunction

    function automatic int unsigned obs_idx(int k);
        case (k)
            0:       return 32'(idx0);
            1:       return 32'(idx1);
            default: return 32'(idx2);
        endcase
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    endtask

    task automatic model_update();
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_busy[k] = 0; m_idx[k] = 0; m_s[k] = minit[k]; m_done[k] = 0; m_err[k] = 0;
            end else begin
                if (m_busy[k] && m_s[k] == 0) m_err[k] = 1;
                m_done[k] = 0;
                if (start[k]) begin
                    m_busy[k] = 1; m_idx[k] = 0; m_s[k] = minit[k];
                end else if (m_busy[k] && step[k]) begin
                    if (m_idx[k] == mr[k] - 1) begin
                        m_busy[k] = 0; m_idx[k] = 0; m_s[k] = minit[k]; m_done[k] = 1;
                    end else begin
                        m_idx[k]++;
                        m_s[k] = model_next(m_s[k], mtaps[k], mw[k]);
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk("busy", k, 32'(busy[k]), 32'(m_busy[k]));
            chk("round_idx", k, obs_idx(k), m_idx[k]);
            chk("lc", k, 32'(lc[k]), m_s[k]);
            chk("lc_rev", k, 32'(lc_rev[k]), model_rev(m_s[k], mw[k]));
            chk("last", k, 32'(last[k]), 32'(m_busy[k] && m_idx[k] == mr[k] - 1));
            chk("done", k, 32'(done[k]), 32'(m_done[k]));
            chk("err", k, 32'(err[k]), 32'(m_err[k]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
        check_all();
        for (int k = 0; k < 3; k++) if (done[k]) done_seen[k]++;
    endtask

    task automatic do_steps(input int k, input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            step[k] = 1'b0;
            repeat ($urandom_range(0, max_gap)) cycle();
            step[k] = 1'b1;
            cycle();
        end
        step[k] = 1'b0;
    endtask

    task automatic do_start(input int k);
        start[k] = 1'b1;
        cycle();
        start[k] = 1'b0;
    endtask

    int unsigned seq88 [5] = '{'h05, 'h0A, 'h14, 'h29, 'h13};
    int done_at [3];

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0; step[k] = 1'b0; done_seen[k] = 0; done_at[k] = 0;
        end

        // Reset defaults
        cycle();
        cycle();
        chk("rst_lc", 0, 32'(lc[0]), 32'h0005);
        chk("rst_busy", 0, 32'(busy[0]), 0);
        chk("rst_idx", 0, obs_idx(0), 0);
        rst = 1'b0;
        cycle();

        // Known forward sequence and reversed alignment
        do_start(0);
        for (int i = 0; i < 5; i++) begin
            chk("seq_lc", 0, 32'(lc[0]), seq88[i]);
            chk("seq_idx", 0, obs_idx(0), i);
            if (i == 0) chk("seq_rev0", 0, 32'(lc_rev[0]), 32'hA000);
            if (i == 1) chk("seq_rev1", 0, 32'(lc_rev[0]), 32'h5000);
            step[0] = 1'b1;
            cycle();
        end
        step[0] = 1'b0;

        // Full call with random gaps
        do_start(0);
        done_seen[0] = 0;
        do_steps(0, 45, 3);
        chk("full_done_cnt", 0, 32'(done_seen[0]), 1);
        chk("full_busy", 0, 32'(busy[0]), 0);
        chk("full_lc", 0, 32'(lc[0]), 32'h0005);
        cycle();
        chk("full_done_pulse", 0, 32'(done[0]), 0);

        // Abort and restart
        do_start(0);
        do_steps(0, 10, 1);
        done_seen[0] = 0;
        do_start(0);
        chk("abort_idx", 0, obs_idx(0), 0);
        chk("abort_lc", 0, 32'(lc[0]), 32'h0005);
        chk("abort_done", 0, 32'(done_seen[0]), 0);
        do_steps(0, 45, 0);
        chk("abort_call_done", 0, 32'(done_seen[0]), 1);

        // Priorities
        do_start(0);
        do_steps(0, 3, 0);
        start[0] = 1'b1; step[0] = 1'b1;
        cycle();
        start[0] = 1'b0; step[0] = 1'b0;
        chk("start_wins_idx", 0, obs_idx(0), 0);
        chk("start_wins_lc", 0, 32'(lc[0]), 32'h0005);
        do_steps(0, 5, 0);
        done_seen[0] = 0;
        rst = 1'b1; step[0] = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_mid_busy", 0, 32'(busy[0]), 0);
        chk("rst_mid_idx", 0, obs_idx(0), 0);
        repeat (3) cycle();
        step[0] = 1'b0;
        chk("rst_mid_no_done", 0, 32'(done_seen[0]), 0);
        chk("idle_step_lc", 0, 32'(lc[0]), 32'h0005);
        chk("idle_step_idx", 0, obs_idx(0), 0);

        // Variant sweep: 128 and 256
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        start[1] = 1'b1; start[2] = 1'b1;
        cycle();
        start[1] = 1'b0; start[2] = 1'b0;
        done_seen[1] = 0; done_seen[2] = 0;
        step[1] = 1'b1; step[2] = 1'b1;
        for (int n = 0; n < 150; n++) begin
            if (busy[1]) begin
                chk("dup128", 1, 32'(seen1.exists(int'(lc[1]))), 0);
                seen1[int'(lc[1])] = 1;
            end
            if (busy[2]) begin
                chk("dup256", 2, 32'(seen2.exists(int'(lc[2]))), 0);
                seen2[int'(lc[2])] = 1;
            end
            cycle();
            if (done[1] && done_at[1] == 0) done_at[1] = n + 1;
            if (done[2] && done_at[2] == 0) done_at[2] = n + 1;
        end
        step[1] = 1'b0; step[2] = 1'b0;
        chk("v128_done_at", 1, 32'(done_at[1]), 70);
        chk("v256_done_at", 2, 32'(done_at[2]), 140);
        chk("v128_done_cnt", 1, 32'(done_seen[1]), 1);
        chk("v256_done_cnt", 2, 32'(done_seen[2]), 1);
        chk("v128_err", 1, 32'(err[1]), 0);
        chk("v256_err", 2, 32'(err[2]), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/spongent_round_counter.md
Name: spongent_round_counter

Overview:
- Sequential, parametrised round-constant generator for the Spongent permutation.
- Holds the round-counter LFSR and advances it one state per permutation round.
- Outputs the forward constant and the bit-reversed constant, both aligned for XOR into the state word, plus round index, last-round and done flags.
- Sits beside the permutation datapath and is driven by the permutation controller through a start/step handshake.

Parameters:
- LFSR_W, 6: LFSR width in bits (6/7/8/9 per Spongent variant).
- TAPS, 6'b110000: feedback mask, bit i set means state[i] is XORed into the feedback. Default is x^6+x^5+1.
- INIT, 6'h05: LFSR value for round 0.
- ROUNDS, 45: rounds per permutation call (R).
- OUT_W, 16: width of the aligned constant outputs; must satisfy OUT_W >= LFSR_W.
- IDX_W, $clog2(ROUNDS): width of round_idx.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a permutation call. Reloads INIT and sets round_idx to 0.
- step  in  1  advance one round; honoured only while busy.
- busy  out  1  a call is in progress.
- round_idx  out  IDX_W  index of the current round, 0..ROUNDS-1.
- lc  out  OUT_W  LFSR state, zero-extended into the LSBs.
- lc_rev  out  OUT_W  LFSR state bit-reversed over LFSR_W, placed in bits [OUT_W-1 -: LFSR_W]; all other bits are 0.
- last  out  1  busy && round_idx==ROUNDS-1.
- done  out  1  one-cycle pulse after the final round is stepped.
- err  out  1  sticky flag, set if the LFSR reaches all-zero (lock-up).

Behaviour:
- Reset (rst=1 at the clock edge): busy=0, done=0, err=0, round_idx=0, state=INIT. Outputs are therefore lc=INIT and last=0.
- LFSR update: fb = ^(state & TAPS); next = {state[LFSR_W-2:0], fb}. The update is a left shift.
- lc and lc_rev are combinational from the state register. Latency from state to outputs is 0 cycles.
- IDLE (busy=0):
  - start=1: next cycle busy=1, round_idx=0, state=INIT.
  - step is ignored.
  - done is low except for its pulse.
- RUN (busy=1), step=1 and round_idx<ROUNDS-1: state advances, round_idx increments.
- RUN, step=1 and round_idx==ROUNDS-1:
  - Next cycle busy=0, done=1 for exactly one cycle.
  - round_idx returns to 0 and state reloads INIT.
- RUN, step=0: all registers hold. Gaps between steps are allowed.
- start while busy: aborts and restarts. Next cycle round_idx=0 and state=INIT; done is not pulsed.
- start and step in the same cycle: start wins; step is dropped.
- rst has priority over start and step. rst mid-call returns to IDLE with no done.
- err: set when busy and state==0. Cleared only by rst. The block keeps operating after err is set.
- round_idx never wraps past ROUNDS-1.
- Elaboration checks (error out): OUT_W >= LFSR_W, TAPS[LFSR_W-1]=1, INIT != 0, ROUNDS >= 1.

Decomposition:
- Shared package spongent_pkg holds per-variant constants LFSR_W, TAPS, INIT and ROUNDS:
  - SPONGENT88: 6, 6'b110000, 6'h05, 45
  - SPONGENT128: 7, 7'b1100000, 7'h7A, 70
  - SPONGENT160: 7, 7'b1100000, 7'h45, 90
  - SPONGENT224: 8, 8'b10001110, 8'h01, 120
  - SPONGENT256: 9, 9'b100010000, 9'h9E, 140
- The package also defines a bit_reverse function.
- Sub-module spongent_lfsr_core (parameters LFSR_W, TAPS, INIT; ports clk, rst, load, en, state) holds the state register and feedback logic.
- The top level holds the control FSM, round counter and output alignment.

Test Plan:
1. Reset, defaults. Assert rst -> busy=0, done=0, err=0, lc=16'h0005, round_idx=0.
2. Sequence check. Pulse start, then step each cycle -> lc=0x05, 0x0A, 0x14, 0x29, 0x13 for round_idx 0..4; lc_rev at idx0=16'hA000, idx1=16'h5000.
3. Full call. start, then 45 steps with random 0-3 cycle gaps -> last=1 only at round_idx=44; done high for one cycle after the 45th step; busy=0 and lc=0x05 afterwards.
4. Abort. start, 10 steps, start again -> round_idx=0, lc=0x05, no done pulse; a further 45 steps -> done.
5. Priorities. Assert start and step together -> round_idx=0. Assert rst mid-call with step=1 -> IDLE, no done. Step while idle -> no change.
6. Variant sweep. Instantiate with SPONGENT128 and SPONGENT256 constants -> done after 70 and 140 steps respectively; err stays 0; LFSR visits no duplicate states within one call (bench model cross-check).
